// File: rtl/rv32_pkg.sv
// Shared RV32 register-file types: index width, register count and the
// issued-instruction record carried by the issue scoreboard.
package rv32_pkg;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int REG_IDX_W        = $clog2(NUM_REGS_DEFAULT);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1_sel;
    reg_idx_t rs2_sel;
    reg_idx_t rd_sel;
    logic     rd_wen;
  } issue_instr_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue handshake, writeback/flush inputs and status outputs of the
// issue scoreboard; master = decode/pipeline side, slave = scoreboard.
interface issue_scoreboard_if #(
  parameter int NUM_REGS = rv32_pkg::NUM_REGS_DEFAULT
) ();
  import rv32_pkg::*;

  logic                in_valid;
  logic                in_ready;
  reg_idx_t            in_rs1_sel;
  reg_idx_t            in_rs2_sel;
  reg_idx_t            in_rd_sel;
  logic                in_rd_wen;

  logic                out_valid;
  logic                out_ready;
  reg_idx_t            out_rs1_sel;
  reg_idx_t            out_rs2_sel;
  reg_idx_t            out_rd_sel;
  logic                out_rd_wen;

  logic                wb_valid;
  reg_idx_t            wb_addr;
  logic                flush;

  logic [NUM_REGS-1:0] pending_mask;
  logic                hazard_stall;

  modport master (
    output in_valid, in_rs1_sel, in_rs2_sel, in_rd_sel, in_rd_wen,
    output out_ready, wb_valid, wb_addr, flush,
    input  in_ready, out_valid, out_rs1_sel, out_rs2_sel, out_rd_sel, out_rd_wen,
    input  pending_mask, hazard_stall
  );

  modport slave (
    input  in_valid, in_rs1_sel, in_rs2_sel, in_rd_sel, in_rd_wen,
    input  out_ready, wb_valid, wb_addr, flush,
    output in_ready, out_valid, out_rs1_sel, out_rs2_sel, out_rd_sel, out_rd_wen,
    output pending_mask, hazard_stall
  );

endinterface

// File: rtl/scoreboard_mask.sv
// Pending-write bit vector: two independent clear ports and one set port;
// a set beats a clear on the same index, and bit 0 (x0) is never pending.
module scoreboard_mask
  import rv32_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_a_en,
  input  reg_idx_t            clr_a_idx,
  input  logic                clr_b_en,
  input  reg_idx_t            clr_b_idx,
  output logic [NUM_REGS-1:0] mask_o
);

  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] mask_d;

  // Clears first so that a same-cycle set on the same index survives.
  always_comb begin
    mask_d = mask_q;
    if (clr_a_en) mask_d[clr_a_idx] = 1'b0;
    if (clr_b_en) mask_d[clr_b_idx] = 1'b0;
    if (set_en)   mask_d[set_idx]   = 1'b1;
    mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask_o = mask_q;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: blocks RAW/WAW hazards against outstanding writes
// and holds one issued instruction. Optional SCOREBOARD_PERF_EN adds a stall counter.
module issue_scoreboard
  import rv32_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEFAULT,
  parameter int WB_BYPASS = 1
) (
  input  logic               clk,
  input  logic               resetn,
  issue_scoreboard_if.slave  sb
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles
`endif
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] wb_clr_vec;
  logic [NUM_REGS-1:0] hazard_view;
  logic                wb_clr;
  logic                flush_clr;
  logic                hazard;
  logic                in_ready;
  logic                accept;
  logic                set_en;
  issue_instr_t        in_instr;
  issue_instr_t        out_q;
  issue_instr_t        out_d;
  logic                out_valid_q;
  logic                out_valid_d;

  // Bit 0 of the mask is hard zero, so x0 sources never raise a hazard.
  always_comb begin
    in_instr = '{rs1_sel: sb.in_rs1_sel, rs2_sel: sb.in_rs2_sel,
                 rd_sel: sb.in_rd_sel, rd_wen: sb.in_rd_wen};
    wb_clr     = sb.wb_valid && (sb.wb_addr != '0);
    wb_clr_vec = '0;
    if (wb_clr) wb_clr_vec[sb.wb_addr] = 1'b1;
    hazard_view = (WB_BYPASS != 0) ? (pending & ~wb_clr_vec) : pending;
    hazard = sb.in_valid &&
             (hazard_view[in_instr.rs1_sel] ||
              hazard_view[in_instr.rs2_sel] ||
              (in_instr.rd_wen && hazard_view[in_instr.rd_sel]));
    in_ready  = !hazard && (!out_valid_q || sb.out_ready) && !sb.flush;
    accept    = sb.in_valid && in_ready;
    set_en    = accept && in_instr.rd_wen && (in_instr.rd_sel != '0);
    flush_clr = sb.flush && out_valid_q && out_q.rd_wen && (out_q.rd_sel != '0);
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = in_instr;
      out_valid_d = 1'b1;
    end else if (sb.flush || sb.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  scoreboard_mask #(
    .NUM_REGS (NUM_REGS)
  ) u_mask (
    .clk       (clk),
    .resetn    (resetn),
    .set_en    (set_en),
    .set_idx   (in_instr.rd_sel),
    .clr_a_en  (wb_clr),
    .clr_a_idx (sb.wb_addr),
    .clr_b_en  (flush_clr),
    .clr_b_idx (out_q.rd_sel),
    .mask_o    (pending)
  );

  assign sb.in_ready     = in_ready;
  assign sb.hazard_stall = hazard;
  assign sb.pending_mask = pending;
  assign sb.out_valid    = out_valid_q;
  assign sb.out_rs1_sel  = out_q.rs1_sel;
  assign sb.out_rs2_sel  = out_q.rs2_sel;
  assign sb.out_rd_sel   = out_q.rd_sel;
  assign sb.out_rd_wen   = out_q.rd_wen;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (hazard && (perf_cnt_q != '1)) perf_cnt_d = perf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cycles = perf_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus random
// traffic against an array-based reference model (WB_BYPASS=1 and =0 copies).
module tb_issue_scoreboard;
  import rv32_pkg::*;

  logic     clk = 1'b0;
  logic     resetn = 1'b0;
  logic     in_valid, in_rd_wen, out_ready, wb_valid, flush;
  reg_idx_t in_rs1, in_rs2, in_rd, wb_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scoreboard_if sb1 ();
  issue_scoreboard_if sb0 ();

  assign sb1.in_valid   = in_valid;   assign sb0.in_valid   = in_valid;
  assign sb1.in_rs1_sel = in_rs1;     assign sb0.in_rs1_sel = in_rs1;
  assign sb1.in_rs2_sel = in_rs2;     assign sb0.in_rs2_sel = in_rs2;
  assign sb1.in_rd_sel  = in_rd;      assign sb0.in_rd_sel  = in_rd;
  assign sb1.in_rd_wen  = in_rd_wen;  assign sb0.in_rd_wen  = in_rd_wen;
  assign sb1.out_ready  = out_ready;  assign sb0.out_ready  = out_ready;
  assign sb1.wb_valid   = wb_valid;   assign sb0.wb_valid   = wb_valid;
  assign sb1.wb_addr    = wb_addr;    assign sb0.wb_addr    = wb_addr;
  assign sb1.flush      = flush;      assign sb0.flush      = flush;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf1, perf0;
  issue_scoreboard #(.WB_BYPASS(1)) dut1 (.clk(clk), .resetn(resetn), .sb(sb1), .perf_stall_cycles(perf1));
  issue_scoreboard #(.WB_BYPASS(0)) dut0 (.clk(clk), .resetn(resetn), .sb(sb0), .perf_stall_cycles(perf0));
`else
  issue_scoreboard #(.WB_BYPASS(1)) dut1 (.clk(clk), .resetn(resetn), .sb(sb1));
  issue_scoreboard #(.WB_BYPASS(0)) dut0 (.clk(clk), .resetn(resetn), .sb(sb0));
`endif

  // Reference model of the bypass-enabled scoreboard (dut1).
  bit          m_pend[32];
  bit          m_ov;
  int          m_rs1, m_rs2, m_rd;
  bit          m_wen;
  int unsigned m_perf;

  function automatic bit m_blocked(int r);
    return (r != 0) && m_pend[r] && !(wb_valid && (int'(wb_addr) == r));
  endfunction

  function automatic bit m_hazard();
    return in_valid && (m_blocked(int'(in_rs1)) || m_blocked(int'(in_rs2)) ||
                        (in_rd_wen && m_blocked(int'(in_rd))));
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && (!m_ov || out_ready) && !flush;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_ov = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wen = 0; m_perf = 0;
  endtask

  task automatic tick();
    bit acc, hz;
    bit np[32];
    acc = in_valid && m_ready();
    hz  = m_hazard();
    np  = m_pend;
    if (wb_valid && wb_addr != 0) np[wb_addr] = 1'b0;
    if (flush && m_ov && m_wen && m_rd != 0) np[m_rd] = 1'b0;
    if (acc && in_rd_wen && in_rd != 0) np[in_rd] = 1'b1;
    @(posedge clk);
    m_pend = np;
    if (acc) begin
      m_ov = 1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_wen = in_rd_wen;
    end else if (flush || out_ready) begin
      m_ov = 0;
    end
    if (hz && m_perf != 32'hFFFF_FFFF) m_perf++;
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_rd_wen = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    out_ready = 1; wb_valid = 0; wb_addr = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    drive_idle();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic set_instr(bit v, int rs1, int rs2, int rd, bit wen);
    in_valid = v; in_rs1 = reg_idx_t'(rs1); in_rs2 = reg_idx_t'(rs2);
    in_rd = reg_idx_t'(rd); in_rd_wen = wen;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 0;
    drive_idle();
    set_instr(1, 1, 2, 9, 1);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sb1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", sb1.out_valid); end
    checks++; if (sb1.pending_mask !== 32'h0) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 0", sb1.pending_mask); end
    checks++; if (sb1.out_rd_sel !== 5'd0 || sb1.out_rd_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_rd: got %0d/%b expected 0/0", sb1.out_rd_sel, sb1.out_rd_wen); end
    @(negedge clk);
    drive_idle();
    resetn = 1;
  endtask

  task automatic test_raw();
    do_reset();
    set_instr(1, 0, 0, 5, 1);
    #1;
    checks++; if (sb1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_first_ready: got %b expected 1", sb1.in_ready); end
    tick();
    checks++; if (sb1.pending_mask !== m_mask() || m_mask() !== 32'h20) begin errors++; $display("[TB] FAIL raw_pending5: got %h expected %h", sb1.pending_mask, 32'h20); end
    @(negedge clk);
    set_instr(1, 5, 0, 6, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (sb1.hazard_stall !== 1'b1 || sb1.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall: got stall=%b ready=%b expected 1/0", sb1.hazard_stall, sb1.in_ready); end
      tick();
      @(negedge clk);
    end
    wb_valid = 1; wb_addr = 5;
    #1;
    checks++; if (sb1.in_ready !== 1'b1 || sb1.hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL raw_bypass_ready: got ready=%b stall=%b expected 1/0", sb1.in_ready, sb1.hazard_stall); end
    checks++; if (sb0.in_ready !== 1'b0 || sb0.hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_nobypass_wait: got ready=%b stall=%b expected 0/1", sb0.in_ready, sb0.hazard_stall); end
    tick();
    checks++; if (sb1.out_valid !== 1'b1 || sb1.out_rd_sel !== 5'd6 || sb1.out_rs1_sel !== 5'd5) begin errors++; $display("[TB] FAIL raw_bypass_issue: got v=%b rd=%0d rs1=%0d expected 1/6/5", sb1.out_valid, sb1.out_rd_sel, sb1.out_rs1_sel); end
    checks++; if (sb1.pending_mask !== 32'h40) begin errors++; $display("[TB] FAIL raw_pending_after_wb: got %h expected 00000040", sb1.pending_mask); end
    @(negedge clk);
    wb_valid = 0; wb_addr = 0;
    #1;
    checks++; if (sb0.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_nobypass_ready: got %b expected 1", sb0.in_ready); end
    tick();
    checks++; if (sb0.out_valid !== 1'b1 || sb0.out_rd_sel !== 5'd6) begin errors++; $display("[TB] FAIL raw_nobypass_issue: got v=%b rd=%0d expected 1/6", sb0.out_valid, sb0.out_rd_sel); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_x0();
    do_reset();
    set_instr(1, 0, 0, 0, 1);
    tick();
    checks++; if (sb1.pending_mask !== 32'h0) begin errors++; $display("[TB] FAIL x0_pending: got %h expected 0", sb1.pending_mask); end
    @(negedge clk);
    set_instr(1, 0, 0, 0, 1);
    #1;
    checks++; if (sb1.hazard_stall !== 1'b0 || sb1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_no_stall: got stall=%b ready=%b expected 0/1", sb1.hazard_stall, sb1.in_ready); end
    tick();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_collision();
    do_reset();
    set_instr(1, 1, 2, 7, 1);
    wb_valid = 1; wb_addr = 7;
    tick();
    checks++; if (sb1.pending_mask[7] !== 1'b1 || sb1.pending_mask !== m_mask()) begin errors++; $display("[TB] FAIL collision_set_wins: got %h expected %h", sb1.pending_mask, m_mask()); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    set_instr(1, 0, 0, 3, 1);
    tick();
    @(negedge clk);
    set_instr(1, 10, 11, 12, 1);
    #1;
    checks++; if (sb1.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready: got %b expected 0", sb1.in_ready); end
    tick();
    checks++; if (sb1.out_valid !== 1'b1 || sb1.out_rd_sel !== 5'd3) begin errors++; $display("[TB] FAIL bp_hold: got v=%b rd=%0d expected 1/3", sb1.out_valid, sb1.out_rd_sel); end
    @(negedge clk);
    flush = 1; out_ready = 1;
    #1;
    checks++; if (sb1.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 0", sb1.in_ready); end
    tick();
    checks++; if (sb1.out_valid !== 1'b0 || sb1.pending_mask[3] !== 1'b0) begin errors++; $display("[TB] FAIL flush_clear: got v=%b p3=%b expected 0/0", sb1.out_valid, sb1.pending_mask[3]); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_instr(1, 20 + i, 0, i, 1);
      #1;
      checks++; if (sb1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, sb1.in_ready); end
      tick();
      checks++; if (sb1.out_valid !== 1'b1 || int'(sb1.out_rd_sel) != i) begin errors++; $display("[TB] FAIL b2b_issue_%0d: got v=%b rd=%0d expected 1/%0d", i, sb1.out_valid, sb1.out_rd_sel, i); end
      @(negedge clk);
    end
    drive_idle();
    #1;
    checks++; if (sb1.pending_mask !== 32'h7E) begin errors++; $display("[TB] FAIL b2b_pending: got %h expected 0000007e", sb1.pending_mask); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_instr(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), ($urandom % 4) != 0);
      out_ready = ($urandom % 4) != 0;
      wb_valid  = ($urandom % 5) < 2;
      wb_addr   = reg_idx_t'($urandom_range(0, 7));
      flush     = ($urandom % 20) == 0;
      #1;
      checks++; if (sb1.in_ready !== m_ready() || sb1.hazard_stall !== m_hazard()) begin errors++; $display("[TB] FAIL rand_comb_%0d: got ready=%b stall=%b expected %b/%b", n, sb1.in_ready, sb1.hazard_stall, m_ready(), m_hazard()); end
      tick();
      checks++; if (sb1.pending_mask !== m_mask() || sb1.out_valid !== m_ov) begin errors++; $display("[TB] FAIL rand_state_%0d: got mask=%h v=%b expected %h/%b", n, sb1.pending_mask, sb1.out_valid, m_mask(), m_ov); end
      if (m_ov) begin
        checks++;
        if (int'(sb1.out_rs1_sel) != m_rs1 || int'(sb1.out_rs2_sel) != m_rs2 ||
            int'(sb1.out_rd_sel) != m_rd || sb1.out_rd_wen !== m_wen) begin
          errors++;
          $display("[TB] FAIL rand_out_%0d: got %0d/%0d/%0d/%b expected %0d/%0d/%0d/%b", n,
                   sb1.out_rs1_sel, sb1.out_rs2_sel, sb1.out_rd_sel, sb1.out_rd_wen, m_rs1, m_rs2, m_rd, m_wen);
        end
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 0;
    set_instr(1, 0, 0, 4, 1);
    tick();
    @(negedge clk);
    drive_idle();
    #2;
    resetn = 0;
    #1;
    checks++; if (sb1.out_valid !== 1'b0 || sb1.pending_mask !== 32'h0 || sb1.out_rd_sel !== 5'd0) begin errors++; $display("[TB] FAIL mid_reset: got v=%b mask=%h rd=%0d expected 0/0/0", sb1.out_valid, sb1.pending_mask, sb1.out_rd_sel); end
    model_clear();
    @(negedge clk);
    resetn = 1;
  endtask

`ifdef SCOREBOARD_PERF_EN
  task automatic test_perf();
    do_reset();
    set_instr(1, 0, 0, 5, 1);
    tick();
    @(negedge clk);
    set_instr(1, 5, 0, 0, 0);
    repeat (10) begin
      tick();
      @(negedge clk);
    end
    #1;
    checks++; if (perf1 !== 32'd10 || m_perf != 10) begin errors++; $display("[TB] FAIL perf_count: got %0d expected 10", perf1); end
    force dut1.perf_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut1.perf_cnt_q;
    tick();
    tick();
    checks++; if (perf1 !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL perf_saturate: got %h expected ffffffff", perf1); end
    @(negedge clk);
    drive_idle();
  endtask
`endif

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drive_idle();
    model_clear();
    test_reset();
    test_raw();
    test_x0();
    test_collision();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SCOREBOARD_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
